// File: rtl/branch_predictor_core.sv
// Branch predictor core: 16-entry table of 2-bit saturating counters, one prediction in flight.
// Optional build macro PREDICTOR_STATS_EN adds saturating resolve/mispredict statistics outputs.
module branch_predictor_core (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pred_req,
  input  logic [10:0] pred_addr,
  input  logic [13:0] latched_branch,
  input  logic [10:0] latched_branch_addr,
  input  logic [10:0] latched_jump_addr,
  input  logic [15:0] latched_W,
  input  logic        latched_CY,
  input  logic        latched_exec_done,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic        pred_busy,
  output logic        mispredict,
  output logic [10:0] redirect_addr
`ifdef PREDICTOR_STATS_EN
  ,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts
`endif
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0][1:0] counters_q, counters_d;
  logic [3:0]       stored_idx_q;
  logic             stored_pred_q;

  logic        pred_fire;
  logic        resolve;
  logic        outcome;
  logic        wrong;
  logic [1:0]  branch_class;
  logic [1:0]  cnt_cur;
  logic [1:0]  cnt_next;
  logic [3:0]  pred_idx;
  logic [10:0] fallthrough_addr;
  logic [10:0] correct_addr;

  // Only the class field and the low index bits matter to the predictor.
  logic unused_bits;
  assign unused_bits = ^{latched_branch[11:0], pred_addr[10:4]};

  assign pred_idx     = pred_addr[3:0];
  assign branch_class = latched_branch[13:12];
  assign pred_fire    = (state_q == IDLE) && pred_req;
  assign resolve      = (state_q == PENDING) && latched_exec_done;
  assign pred_busy    = (state_q == PENDING);

  always_comb begin
    outcome = 1'b0;
    case (branch_class)
      2'b00:   outcome = 1'b0;
      2'b01:   outcome = 1'b1;
      2'b10:   outcome = latched_CY;
      2'b11:   outcome = (latched_W == 16'h0000);
      default: outcome = 1'b0;
    endcase
  end

  assign wrong            = resolve && (outcome != stored_pred_q);
  assign fallthrough_addr = latched_branch_addr + 11'd1;
  assign correct_addr     = outcome ? latched_jump_addr : fallthrough_addr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pred_req) state_d = PENDING;
      PENDING: if (latched_exec_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Update always targets the index captured at prediction time.
  always_comb begin
    cnt_cur = counters_q[stored_idx_q];
    if (outcome) begin
      cnt_next = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'b01;
    end else begin
      cnt_next = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'b01;
    end
  end

  always_comb begin
    counters_d = counters_q;
    if (resolve && (branch_class != 2'b00)) begin
      counters_d[stored_idx_q] = cnt_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      counters_q    <= {16{2'b01}};
      stored_idx_q  <= 4'd0;
      stored_pred_q <= 1'b0;
      pred_valid    <= 1'b0;
      pred_taken    <= 1'b0;
      mispredict    <= 1'b0;
      redirect_addr <= 11'd0;
    end else begin
      state_q    <= state_d;
      counters_q <= counters_d;
      pred_valid <= pred_fire;
      mispredict <= wrong;
      if (pred_fire) begin
        stored_idx_q  <= pred_idx;
        stored_pred_q <= counters_q[pred_idx][1];
        pred_taken    <= counters_q[pred_idx][1];
      end
      if (wrong) begin
        redirect_addr <= correct_addr;
      end
    end
  end

`ifdef PREDICTOR_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches    <= 16'd0;
      stat_mispredicts <= 16'd0;
    end else begin
      if (resolve && (stat_branches != 16'hFFFF)) begin
        stat_branches <= stat_branches + 16'd1;
      end
      if (wrong && (stat_mispredicts != 16'hFFFF)) begin
        stat_mispredicts <= stat_mispredicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_core.sv
// Self-checking bench for branch_predictor_core: reference model plus expectation queues.
// Define PREDICTOR_STATS_EN at compile time to also exercise the statistics outputs.
module tb_branch_predictor_core;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pred_req;
  logic [10:0] pred_addr;
  logic [13:0] latched_branch;
  logic [10:0] latched_branch_addr;
  logic [10:0] latched_jump_addr;
  logic [15:0] latched_W;
  logic        latched_CY;
  logic        latched_exec_done;
  logic        pred_valid;
  logic        pred_taken;
  logic        pred_busy;
  logic        mispredict;
  logic [10:0] redirect_addr;
`ifdef PREDICTOR_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  always #5 clock = ~clock;

  branch_predictor_core dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .pred_req            (pred_req),
    .pred_addr           (pred_addr),
    .latched_branch      (latched_branch),
    .latched_branch_addr (latched_branch_addr),
    .latched_jump_addr   (latched_jump_addr),
    .latched_W           (latched_W),
    .latched_CY          (latched_CY),
    .latched_exec_done   (latched_exec_done),
    .pred_valid          (pred_valid),
    .pred_taken          (pred_taken),
    .pred_busy           (pred_busy),
    .mispredict          (mispredict),
    .redirect_addr       (redirect_addr)
`ifdef PREDICTOR_STATS_EN
    ,
    .stat_branches       (stat_branches),
    .stat_mispredicts    (stat_mispredicts)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        misp;
    logic [10:0] redir;
  } res_exp_t;

  logic     pred_q[$];
  res_exp_t res_q[$];

  logic [1:0]  m_cnt[16];
  logic        m_pred;
  logic [3:0]  m_idx;
  logic [10:0] m_redir;
  int          m_branches;
  int          m_misps;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 2'b01;
    m_redir    = 11'd0;
    m_pred     = 1'b0;
    m_idx      = 4'd0;
    m_branches = 0;
    m_misps    = 0;
  endfunction

  // Applies one resolve to the model and queues the expected DUT response.
  function automatic void model_resolve(input logic [1:0] cls, input logic [15:0] w,
                                        input logic cy, input logic [10:0] baddr,
                                        input logic [10:0] jaddr);
    logic        taken;
    logic        misp;
    logic [10:0] nxt;
    res_exp_t    e;
    case (cls)
      2'b00:   taken = 1'b0;
      2'b01:   taken = 1'b1;
      2'b10:   taken = cy;
      default: taken = (w == 16'h0000);
    endcase
    misp = (taken != m_pred);
    nxt  = baddr + 11'd1;
    if (misp) m_redir = taken ? jaddr : nxt;
    if (cls != 2'b00) begin
      if (taken && m_cnt[m_idx] != 2'b11) m_cnt[m_idx] = m_cnt[m_idx] + 2'b01;
      else if (!taken && m_cnt[m_idx] != 2'b00) m_cnt[m_idx] = m_cnt[m_idx] - 2'b01;
    end
    m_branches++;
    if (misp) m_misps++;
    e.misp  = misp;
    e.redir = m_redir;
    res_q.push_back(e);
  endfunction

  task automatic drive_branch(input logic [1:0] cls, input logic [15:0] w, input logic cy,
                              input logic [10:0] baddr, input logic [10:0] jaddr);
    logic [11:0] junk;
    junk                = 12'($urandom);
    latched_branch      = {cls, junk};
    latched_W           = w;
    latched_CY          = cy;
    latched_branch_addr = baddr;
    latched_jump_addr   = jaddr;
  endtask

  task automatic predict(input logic [10:0] addr, input string tag);
    logic e;
    @(negedge clock);
    pred_req  = 1'b1;
    pred_addr = addr;
    pred_q.push_back(m_cnt[addr[3:0]][1]);
    m_pred = m_cnt[addr[3:0]][1];
    m_idx  = addr[3:0];
    @(negedge clock);
    pred_req = 1'b0;
    e = pred_q.pop_front();
    n_checks++;
    if (pred_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pred_valid: got %b expected 1", tag, pred_valid);
    end
    n_checks++;
    if (pred_taken !== e) begin
      n_fail++;
      $display("FAIL %s pred_taken: got %b expected %b", tag, pred_taken, e);
    end
    n_checks++;
    if (pred_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pred_busy: got %b expected 1", tag, pred_busy);
    end
    @(negedge clock);
    n_checks++;
    if (pred_valid !== 1'b0 || pred_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s pulse_width: got valid=%b busy=%b expected valid=0 busy=1",
               tag, pred_valid, pred_busy);
    end
  endtask

  task automatic resolve(input logic [1:0] cls, input logic [15:0] w, input logic cy,
                         input logic [10:0] baddr, input logic [10:0] jaddr, input string tag);
    res_exp_t e;
    @(negedge clock);
    drive_branch(cls, w, cy, baddr, jaddr);
    latched_exec_done = 1'b1;
    model_resolve(cls, w, cy, baddr, jaddr);
    @(negedge clock);
    latched_exec_done = 1'b0;
    e = res_q.pop_front();
    n_checks++;
    if (mispredict !== e.misp) begin
      n_fail++;
      $display("FAIL %s mispredict: got %b expected %b", tag, mispredict, e.misp);
    end
    n_checks++;
    if (redirect_addr !== e.redir) begin
      n_fail++;
      $display("FAIL %s redirect_addr: got %h expected %h", tag, redirect_addr, e.redir);
    end
    n_checks++;
    if (pred_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_resolve: got %b expected 0", tag, pred_busy);
    end
    @(negedge clock);
    n_checks++;
    if (mispredict !== 1'b0 || redirect_addr !== e.redir) begin
      n_fail++;
      $display("FAIL %s hold: got misp=%b redir=%h expected misp=0 redir=%h",
               tag, mispredict, redirect_addr, e.redir);
    end
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    pred_req          = 1'b0;
    pred_addr         = 11'd0;
    latched_exec_done = 1'b0;
    drive_branch(2'b00, 16'h0, 1'b0, 11'd0, 11'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if ({pred_valid, pred_taken, pred_busy, mispredict} !== 4'b0000 || redirect_addr !== 11'd0)
    begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b t=%b b=%b m=%b r=%h expected all zero",
               pred_valid, pred_taken, pred_busy, mispredict, redirect_addr);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_predict();
    predict(11'h005, "first_predict");
  endtask

  task automatic test_mispredict_taken();
    resolve(2'b01, 16'h1, 1'b0, 11'h005, 11'h123, "misp_taken");
    predict(11'h005, "repredict_taken");
  endtask

  task automatic test_saturate();
    resolve(2'b11, 16'h0000, 1'b0, 11'h005, 11'h040, "sat_1");
    for (int i = 0; i < 2; i++) begin
      predict(11'h005, "sat_pred");
      resolve(2'b11, 16'h0000, 1'b0, 11'h005, 11'h040, "sat_n");
    end
    predict(11'h005, "sat_top");
    resolve(2'b11, 16'h0001, 1'b1, 11'h005, 11'h040, "sat_dec");
    predict(11'h005, "sat_still_taken");
  endtask

  task automatic test_wrap();
    resolve(2'b10, 16'h0000, 1'b0, 11'h7FF, 11'h100, "wrap_redirect");
  endtask

  task automatic test_class00();
    predict(11'h009, "c00_p0");
    resolve(2'b01, 16'h1, 1'b0, 11'h009, 11'h200, "c00_up");
    predict(11'h009, "c00_p1");
    resolve(2'b00, 16'h0, 1'b1, 11'h3A0, 11'h200, "c00_resolve");
    predict(11'h009, "c00_unchanged");
    resolve(2'b10, 16'h0, 1'b1, 11'h009, 11'h210, "c00_close");
  endtask

  task automatic test_exec_done_idle();
    @(negedge clock);
    drive_branch(2'b01, 16'h0, 1'b1, 11'h00C, 11'h555);
    latched_exec_done = 1'b1;
    @(negedge clock);
    latched_exec_done = 1'b0;
    n_checks++;
    if (mispredict !== 1'b0 || pred_busy !== 1'b0 || redirect_addr !== m_redir) begin
      n_fail++;
      $display("FAIL exec_done_idle: got m=%b b=%b r=%h expected m=0 b=0 r=%h",
               mispredict, pred_busy, redirect_addr, m_redir);
    end
    predict(11'h00C, "idle_counter_kept");
    resolve(2'b00, 16'h0, 1'b0, 11'h00C, 11'h000, "idle_close");
  endtask

  task automatic test_ignore_req_pending();
    predict(11'h005, "ign_p");
    @(negedge clock);
    pred_req  = 1'b1;
    pred_addr = 11'h009;
    @(negedge clock);
    pred_req = 1'b0;
    n_checks++;
    if (pred_valid !== 1'b0 || pred_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_req_pending: got v=%b b=%b expected v=0 b=1", pred_valid, pred_busy);
    end
    // Resolve with a different PC so a wrong-index update would be visible later.
    resolve(2'b01, 16'h1, 1'b0, 11'h00E, 11'h0AA, "ign_resolve");
    predict(11'h00E, "ign_other_idx");
    resolve(2'b00, 16'h0, 1'b0, 11'h00E, 11'h000, "ign_close");
  endtask

  task automatic test_collision();
    res_exp_t e;
    predict(11'h003, "coll_p");
    @(negedge clock);
    pred_req  = 1'b1;
    pred_addr = 11'h004;
    drive_branch(2'b01, 16'h1, 1'b0, 11'h003, 11'h321);
    latched_exec_done = 1'b1;
    model_resolve(2'b01, 16'h1, 1'b0, 11'h003, 11'h321);
    @(negedge clock);
    pred_req          = 1'b0;
    latched_exec_done = 1'b0;
    e = res_q.pop_front();
    n_checks++;
    if (pred_valid !== 1'b0 || pred_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_state: got v=%b b=%b expected v=0 b=0", pred_valid, pred_busy);
    end
    n_checks++;
    if (mispredict !== e.misp || redirect_addr !== e.redir) begin
      n_fail++;
      $display("FAIL collision_resolve: got m=%b r=%h expected m=%b r=%h",
               mispredict, redirect_addr, e.misp, e.redir);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [10:0] a;
      logic [1:0]  c;
      logic [15:0] w;
      a = 11'($urandom);
      c = 2'($urandom);
      w = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      predict(a, "b2b_pred");
      resolve(c, w, 1'($urandom), 11'($urandom), 11'($urandom), "b2b_resolve");
    end
  endtask

  task automatic test_reset_pending();
    predict(11'h005, "rp_a");
    resolve(2'b01, 16'h1, 1'b0, 11'h005, 11'h011, "rp_up1");
    predict(11'h005, "rp_b");
    resolve(2'b01, 16'h1, 1'b0, 11'h005, 11'h011, "rp_up2");
    predict(11'h005, "rp_pending");
    @(negedge clock);
    reset_n   = 1'b0;
    pred_req  = 1'b1;
    pred_addr = 11'h009;
    drive_branch(2'b00, 16'h0, 1'b0, 11'h005, 11'h011);
    latched_exec_done = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({pred_valid, pred_taken, pred_busy, mispredict} !== 4'b0000 || redirect_addr !== 11'd0)
    begin
      n_fail++;
      $display("FAIL reset_async: got v=%b t=%b b=%b m=%b r=%h expected all zero",
               pred_valid, pred_taken, pred_busy, mispredict, redirect_addr);
    end
    @(negedge clock);
    n_checks++;
    if (mispredict !== 1'b0 || pred_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: got m=%b b=%b expected 0 0", mispredict, pred_busy);
    end
    latched_exec_done = 1'b0;
    reset_n = 1'b1;
    m_pred  = m_cnt[9][1];
    m_idx   = 4'd9;
    @(negedge clock);
    pred_req = 1'b0;
    n_checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_req_after_reset: got v=%b t=%b b=%b expected 1 0 1",
               pred_valid, pred_taken, pred_busy);
    end
    resolve(2'b01, 16'h1, 1'b0, 11'h009, 11'h0F0, "rp_close");
    predict(11'h005, "rp_counter_reset");
    resolve(2'b00, 16'h0, 1'b0, 11'h005, 11'h000, "rp_final");
  endtask

`ifdef PREDICTOR_STATS_EN
  task automatic test_stats();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    predict(11'h005, "st_p1");
    resolve(2'b00, 16'h0, 1'b0, 11'h005, 11'h000, "st_r1");
    predict(11'h005, "st_p2");
    resolve(2'b01, 16'h0, 1'b0, 11'h005, 11'h077, "st_r2");
    predict(11'h006, "st_p3");
    resolve(2'b10, 16'h0, 1'b0, 11'h006, 11'h000, "st_r3");
    n_checks++;
    if (stat_branches !== 16'(m_branches)) begin
      n_fail++;
      $display("FAIL stat_branches: got %0d expected %0d", stat_branches, m_branches);
    end
    n_checks++;
    if (stat_mispredicts !== 16'(m_misps)) begin
      n_fail++;
      $display("FAIL stat_mispredicts: got %0d expected %0d", stat_mispredicts, m_misps);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_predict();
    test_mispredict_taken();
    test_saturate();
    test_wrap();
    test_class00();
    test_exec_done_idle();
    test_ignore_req_pending();
    test_collision();
    test_back_to_back();
    test_reset_pending();
`ifdef PREDICTOR_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
